// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the register file and its clear sequencer.
//   DEF_ADDR_WIDTH / DEF_DATA_WIDTH : default register-number and register widths
//   REG_ZERO                        : hard-wired zero register number
//   state_e                         : clear-sweep FSM state encoding
package regfile_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 5;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned REG_ZERO       = 0;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq: reset clear-sweep sequencer for the register file.
// After reset it walks ClrAddr over every entry, one per cycle, then parks in READY.
// Ports:
//   clk     : clock, rising edge
//   resetn  : synchronous active-low reset; restarts the sweep from entry 0
//   Busy    : sweep in progress (decoded from the state register only)
//   ClrEn   : write a zero to ClrAddr on this edge
//   ClrAddr : entry being cleared
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  output logic                  Busy,
  output logic                  ClrEn,
  output logic [ADDR_WIDTH-1:0] ClrAddr
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = {ADDR_WIDTH{1'b1}};

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Next state: leave CLEAR at the terminal count so the pointer never wraps
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      CLEAR: begin
        if (clr_ptr_q == LastAddr) begin
          state_d = READY;
        end else begin
          clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(1);
        end
      end
      READY:   ;
      default: state_d = CLEAR;
    endcase
  end

  // Outputs depend on registered state only
  always_comb begin
    Busy    = (state_q == CLEAR);
    ClrEn   = (state_q == CLEAR);
    ClrAddr = clr_ptr_q;
  end

endmodule

// File: rtl/regfile_wb.sv
// regfile_wb: register file with one write-back port and two combinational read ports.
// Storage has a single write port (RAM-inferable) and is zeroed by a post-reset sweep.
// Ports:
//   clk, resetn          : clock, synchronous active-low reset
//   RegWrite             : write-back enable
//   WriteReg, WriteData  : write-back destination and value (r0 writes are dropped)
//   ReadReg1, ReadReg2   : source register numbers
//   ReadData1, ReadData2 : source values, with same-cycle write-through bypass
//   Busy                 : clear sweep in progress; writes dropped, reads return 0
module regfile_wb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] WriteReg,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [ADDR_WIDTH-1:0] ReadReg1,
  input  logic [ADDR_WIDTH-1:0] ReadReg2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  output logic                  Busy
);

  localparam int unsigned           Depth   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] RegZero = ADDR_WIDTH'(REG_ZERO);

  logic                  busy;
  logic                  clr_en;
  logic [ADDR_WIDTH-1:0] clr_addr;

  logic                  wb_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_q [Depth];

  regfile_clear_seq #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_clear_seq (
    .clk    (clk),
    .resetn (resetn),
    .Busy   (busy),
    .ClrEn  (clr_en),
    .ClrAddr(clr_addr)
  );

  assign Busy  = busy;
  assign wb_en = !busy && RegWrite && (WriteReg != RegZero);

  // Single write port shared by the sweep and write-back; nothing is written on a reset edge
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = WriteReg;
    mem_wdata = WriteData;
    if (resetn) begin
      if (clr_en) begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr;
        mem_wdata = '0;
      end else if (wb_en) begin
        mem_we = 1'b1;
      end
    end
  end

  // No reset on the array so it maps onto RAM; the sweep provides the clear
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Read ports: zero while sweeping or for r0, then bypass, then array
  always_comb begin
    ReadData1 = '0;
    if (!busy && (ReadReg1 != RegZero)) begin
      if (RegWrite && (WriteReg == ReadReg1)) begin
        ReadData1 = WriteData;
      end else begin
        ReadData1 = mem_q[ReadReg1];
      end
    end
  end

  always_comb begin
    ReadData2 = '0;
    if (!busy && (ReadReg2 != RegZero)) begin
      if (RegWrite && (WriteReg == ReadReg2)) begin
        ReadData2 = WriteData;
      end else begin
        ReadData2 = mem_q[ReadReg2];
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb: directed bench for regfile_wb. Expected read values are queued when
// the read addresses are driven and popped when the outputs are sampled.
module tb_regfile_wb;

  logic        clk;
  logic        resetn;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic        Busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] sb_q[$];
  string       tag_q[$];

  regfile_wb dut (
    .clk      (clk),
    .resetn   (resetn),
    .RegWrite (RegWrite),
    .WriteReg (WriteReg),
    .WriteData(WriteData),
    .ReadReg1 (ReadReg1),
    .ReadReg2 (ReadReg2),
    .ReadData1(ReadData1),
    .ReadData2(ReadData2),
    .Busy     (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Advance past one rising edge; inputs are driven 2 time units after the edge
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_busy(input string tag, input logic exp);
    #1;
    check32(tag, {31'd0, Busy}, {31'd0, exp});
  endtask

  // Drive both read addresses and queue the values they must return
  task automatic drive_rd(input string tag, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [31:0] e1, input logic [31:0] e2);
    ReadReg1 = r1;
    ReadReg2 = r2;
    sb_q.push_back({e1, e2});
    tag_q.push_back(tag);
  endtask

  task automatic pop_check();
    logic [63:0] e;
    string       t;
    #1;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    check32({t, "/rd1"}, ReadData1, e[63:32]);
    check32({t, "/rd2"}, ReadData2, e[31:0]);
  endtask

  task automatic write_reg(input logic [4:0] r, input logic [31:0] d);
    RegWrite  = 1'b1;
    WriteReg  = r;
    WriteData = d;
    step();
    RegWrite  = 1'b0;
  endtask

  // Count edges until Busy falls, bounded so a stuck sweep still reaches the summary
  task automatic edges_to_ready(output int n);
    n = 0;
    #1;
    while (Busy && n < 100) begin
      step();
      n++;
      #1;
    end
  endtask

  initial begin
    int n;
    resetn    = 1'b0;
    RegWrite  = 1'b0;
    WriteReg  = '0;
    WriteData = '0;
    ReadReg1  = 5'd3;
    ReadReg2  = 5'd31;

    // Held reset
    repeat (3) step();
    check_busy("reset_busy", 1'b1);
    drive_rd("reset_rd", 5'd3, 5'd31, 32'h0, 32'h0);
    pop_check();

    // First sweep: Busy high for exactly 32 edges, reads zero, write at edge 2 dropped
    resetn = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      RegWrite  = (e == 2);
      WriteReg  = 5'd3;
      WriteData = 32'hFF;
      check_busy($sformatf("sweep_busy_e%0d", e), 1'b1);
      if (e <= 3 || e == 32) begin
        drive_rd($sformatf("sweep_rd_e%0d", e), 5'd3, 5'd31, 32'h0, 32'h0);
        pop_check();
      end
      step();
    end
    RegWrite = 1'b0;
    check_busy("sweep_done", 1'b0);

    // Every register swept to zero, including r3 written during the sweep
    for (int r = 1; r < 32; r++) begin
      drive_rd($sformatf("clear_r%0d", r), 5'(r), 5'(32 - r), 32'h0, 32'h0);
      pop_check();
    end

    // Basic write then read next cycle
    write_reg(5'd5, 32'hDEADBEEF);
    drive_rd("wr_r5", 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);
    pop_check();

    // r0 is hard-wired, also during the write cycle itself
    RegWrite  = 1'b1;
    WriteReg  = 5'd0;
    WriteData = 32'h12345678;
    drive_rd("wr_r0_same", 5'd0, 5'd0, 32'h0, 32'h0);
    pop_check();
    step();
    RegWrite = 1'b0;
    drive_rd("wr_r0_after", 5'd0, 5'd5, 32'h0, 32'hDEADBEEF);
    pop_check();

    // Bypass: old value in array until the edge, new value visible combinationally
    write_reg(5'd7, 32'h11111111);
    RegWrite  = 1'b1;
    WriteReg  = 5'd7;
    WriteData = 32'hA5A5A5A5;
    drive_rd("bypass_both", 5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5);
    pop_check();
    drive_rd("bypass_one", 5'd7, 5'd5, 32'hA5A5A5A5, 32'hDEADBEEF);
    pop_check();
    RegWrite = 1'b0;
    drive_rd("bypass_old", 5'd7, 5'd7, 32'h11111111, 32'h11111111);
    pop_check();
    write_reg(5'd7, 32'hA5A5A5A5);
    drive_rd("bypass_stored", 5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5);
    pop_check();

    // Reset in READY clears r9
    write_reg(5'd9, 32'h55);
    drive_rd("r9_written", 5'd9, 5'd5, 32'h55, 32'hDEADBEEF);
    pop_check();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check_busy("ready_reset_busy", 1'b1);
    drive_rd("ready_reset_rd", 5'd9, 5'd7, 32'h0, 32'h0);
    pop_check();
    edges_to_ready(n);
    check32("ready_reset_len", 32'(n), 32'd32);
    drive_rd("r9_cleared", 5'd9, 5'd5, 32'h0, 32'h0);
    pop_check();

    // Mid-sweep reset at sweep edge 10 restarts the full 32-edge sweep
    write_reg(5'd12, 32'hCAFEF00D);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    repeat (9) step();
    resetn = 1'b0;
    step();
    check_busy("midsweep_busy_in_reset", 1'b1);
    resetn = 1'b1;
    edges_to_ready(n);
    check32("midsweep_len", 32'(n), 32'd32);
    drive_rd("midsweep_cleared", 5'd12, 5'd7, 32'h0, 32'h0);
    pop_check();

    // Independent ports after the restart
    write_reg(5'd1, 32'h0000_0001);
    write_reg(5'd31, 32'h8000_0000);
    drive_rd("ports_indep", 5'd31, 5'd1, 32'h8000_0000, 32'h0000_0001);
    pop_check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb.md
# regfile_wb

Register file for the single-cycle datapath. It receives the 5-bit destination-register number chosen by the write-back destination select (rt/rd) mux and commits write-back data at the selected address. It also serves the two decode-stage source reads. Storage is a single-write-port array that can be inferred as RAM, so reset clears it with a sequential sweep that takes one entry per cycle; `Busy` is high during the sweep.

## Interface
- `DATA_WIDTH`, default 32: register width.
- `ADDR_WIDTH`, default 5: register-number width. Depth is 2^ADDR_WIDTH.
- `clk`, in, 1: clock. All state updates on the rising edge.
- `resetn`, in, 1: reset, synchronous, active-low.
- `RegWrite`, in, 1: write enable from the write-back stage.
- `WriteReg`, in, ADDR_WIDTH: destination register number, driven by the destination select mux.
- `WriteData`, in, DATA_WIDTH: write-back value.
- `ReadReg1`, in, ADDR_WIDTH: source A register number.
- `ReadReg2`, in, ADDR_WIDTH: source B register number.
- `ReadData1`, out, DATA_WIDTH: source A value.
- `ReadData2`, out, DATA_WIDTH: source B value.
- `Busy`, out, 1: clear sweep in progress. The controller stalls while this is high.

## Operation
- FSM has two states, CLEAR and READY. A pointer `ClrPtr` (ADDR_WIDTH bits) drives the sweep.
- Reset: any edge with `resetn`=0 sets state to CLEAR and `ClrPtr` to 0. The array is not written on that edge.
- CLEAR, on each edge with `resetn`=1:
  - array[`ClrPtr`] is written with 0.
  - If `ClrPtr` = 2^ADDR_WIDTH-1, state goes to READY. Otherwise `ClrPtr` increments by 1.
- READY:
  - On an edge with `RegWrite`=1 and `WriteReg`≠0, array[`WriteReg`] is written with `WriteData`.
  - Writes to register 0 are dropped.
- Writes during CLEAR are dropped silently. Producers must hold the write until `Busy`=0.
- Reads are combinational.
  - `ReadDataN` = 0 when the state is CLEAR or `ReadRegN`=0.
  - Otherwise, if `RegWrite`=1 and `WriteReg`=`ReadRegN`, `ReadDataN` = `WriteData` (write-through bypass). Same-cycle write-back is visible to decode.
  - Otherwise `ReadDataN` = array[`ReadRegN`].
- Both read ports are independent. Both may name the same register, and both may hit the bypass at once.
- No arithmetic beyond the `ClrPtr` increment. `ClrPtr` never wraps, because the FSM leaves CLEAR at the terminal count.

## Timing
- Reset values:
  - `Busy`=1.
  - `ReadData1`=`ReadData2`=0.
  - `ClrPtr`=0.
  - State is CLEAR.
  - Array contents are undefined until swept. They are never observable, because reads return 0 while `Busy`=1.
- Sweep duration: with `resetn` released before edge E1, edges E1..E(2^ADDR_WIDTH) clear entries 0..2^ADDR_WIDTH-1. `Busy` falls after edge E(2^ADDR_WIDTH), which is edge 32 by default.
- Holding `resetn` low keeps `ClrPtr` at 0 and `Busy`=1 indefinitely.
- Reset mid-sweep or mid-operation restarts the sweep from entry 0. Contents already written are cleared again.
- Write latency: data is stored at the edge. It is visible on the read ports combinationally in the same cycle via the bypass, and from the array in the next cycle.
- Read latency: zero cycles, purely combinational from address to data.
- `Busy` is registered. It is a function of state only, with no combinational path from inputs.

## Structure
- Shared package `regfile_pkg`:
  - `ADDR_WIDTH` and `DATA_WIDTH` defaults.
  - `REG_ZERO` = 0.
  - State encoding: CLEAR = 1'b0, READY = 1'b1.
- One sub-module, `regfile_clear_seq`: owns the FSM and `ClrPtr`, and outputs `Busy`, `ClrEn` and `ClrAddr`.
- The top level muxes the array write port between the sweep and write-back, and implements the read/bypass logic.

## Test plan
- Reset, then release: `Busy`=1 for exactly 32 edges and reads return 0 throughout. After that, `Busy`=0, and reading every register 1..31 returns 0.
- Writes with `Busy`=0:
  - Write 0xDEADBEEF to r5, then read r5 on both ports the next cycle: both return 0xDEADBEEF.
  - Write 0x12345678 to r0: r0 reads 0.
- Bypass: in one cycle, assert `RegWrite`=1, `WriteReg`=7, `WriteData`=0xA5A5A5A5, `ReadReg1`=7, `ReadReg2`=7. Both outputs = 0xA5A5A5A5 in that same cycle, while array r7 still holds its old value until the edge.
- Write during sweep: `RegWrite`=1 to r3 = 0xFF at sweep edge 2. After the sweep, r3 reads 0.
- Mid-sweep reset: pulse `resetn` low for one edge at sweep edge 10. `Busy` stays high, and after release it stays high for a further 32 edges.
- Reset in READY: write r9 = 0x55, then apply reset. After the new sweep, r9 reads 0.
